regfile_reader: RTL and testbench
=================================

// Module: regfile_reader
// PURPOSE
//  Read-side sequencer for the 8-bit register storage. On a START command it
//  reads LEN consecutive entries beginning at BASE, wrapping modulo DEPTH.
//  It drives the storage read port and streams each word out on a
//  valid/ready interface with a LAST marker. It sits between the register
//  file and downstream consumers such as debug dump and checksum logic.
// PARAMETERS
//  DATA_W  8  width of one register entry / output word
//  DEPTH   8  number of register entries; must be a power of two
//  ADDR_W  3  log2(DEPTH); width of entry address
// PORTS
//  CLK_i          in   1         clock, all logic on posedge
//  RES_i          in   1         reset, synchronous, active-high
//  START_i        in   1         1-cycle command strobe; honoured only in IDLE
//  BASE_ADDR_i    in   ADDR_W    first entry to read, sampled with START_i
//  LEN_i          in   ADDR_W+1  number of words (0..DEPTH), sampled with START_i
//  RF_RD_EN_o     out  1         read strobe to register storage
//  RF_RD_ADDR_o   out  ADDR_W    read address, valid while RF_RD_EN_o=1
//  RF_RD_DATA_i   in   DATA_W    read data, valid the cycle after RF_RD_EN_o
//  OUT_DATA_o     out  DATA_W    streamed word
//  OUT_VALID_o    out  1         OUT_DATA_o is valid
//  OUT_READY_i    in   1         consumer accepts the word when VALID&READY
//  OUT_LAST_o     out  1         current word is the final word of the burst
//  BUSY_o         out  1         high in every state except IDLE
//  DONE_o         out  1         1-cycle pulse after the final word is accepted
// BEHAVIOUR
//  Reset: RES_i=1 at a posedge -> state IDLE; all outputs 0; counters and
//   captured data cleared. Reset aborts a burst in progress immediately;
//   no DONE_o pulse is generated for the aborted burst.
//  FSM states: IDLE, REQ, WAIT, HOLD, FIN.
//   IDLE: START_i=1, LEN_i>0 -> latch BASE into addr, LEN into remaining; go REQ.
//         START_i=1, LEN_i=0 -> go FIN (no beats, no read strobes).
//   REQ : RF_RD_EN_o=1, RF_RD_ADDR_o=addr; go WAIT.
//   WAIT: capture RF_RD_DATA_i into OUT_DATA reg; addr<=addr+1 (mod DEPTH);
//         remaining<=remaining-1; go HOLD.
//   HOLD: OUT_VALID_o=1; OUT_LAST_o=1 iff remaining==0.
//         VALID&READY: if remaining>0 go REQ, else go FIN.
//         Otherwise stay in HOLD; OUT_DATA_o and OUT_LAST_o stay stable.
//   FIN : DONE_o=1 for this single cycle; go IDLE.
//  Latency: START at edge t -> RF_RD_EN_o high in cycle t+1 -> first
//   OUT_VALID_o in cycle t+3. With READY held high, one word every 3 cycles.
//  START_i outside IDLE (including during FIN) is ignored; no queuing.
//  LEN_i>DEPTH is clamped to DEPTH. Address wrap: DEPTH-1 +1 -> 0.
//  RF_RD_EN_o is never asserted outside REQ; RF_RD_ADDR_o is 0 when not in REQ.
//  OUT_DATA_o holds the captured value. Storage writes after capture do not
//   change it. Storage writes between REQ and WAIT are the storage's concern.
//  OUT_VALID_o never drops without a handshake, except on reset.
//  OUT_VALID_o, OUT_LAST_o and DONE_o are driven from state registers only.
// TESTING
//  1 BASE=2, LEN=3, READY=1, RF holds entry k=8'h10+k -> OUT 12,13,14;
//    LAST only on 14; DONE 1 cycle after the 14 handshake.
//  2 BASE=6, LEN=4 -> RF_RD_ADDR sequence 6,7,0,1 (wrap); 4 beats; LAST on
//    the 4th beat.
//  3 LEN=2, READY low 5 cycles in first HOLD -> OUT_DATA/VALID stable for 5
//    cycles, no RD_EN strobe, burst resumes after READY rises.
//  4 LEN=0 -> no RD_EN, no VALID; BUSY 1 cycle; DONE pulse at t+1.
//  5 START pulsed again mid-burst with BASE=0 -> ignored; original sequence
//    completes unchanged.
//  6 RES_i asserted while in HOLD -> next cycle all outputs 0, IDLE; new START
//    with LEN=1 completes normally.

Source files
------------

// File: rtl/regfile_reader.sv
// Burst reader: START(BASE,LEN) walks LEN entries from BASE (mod DEPTH) and streams them out.
// First word valid 3 cycles after START, then one word per 3 cycles; a low OUT_READY_i freezes HOLD.
module regfile_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK_i,
  input  logic              RES_i,
  input  logic              START_i,
  input  logic [ADDR_W-1:0] BASE_ADDR_i,
  input  logic [ADDR_W:0]   LEN_i,
  output logic              RF_RD_EN_o,
  output logic [ADDR_W-1:0] RF_RD_ADDR_o,
  input  logic [DATA_W-1:0] RF_RD_DATA_i,
  output logic [DATA_W-1:0] OUT_DATA_o,
  output logic              OUT_VALID_o,
  input  logic              OUT_READY_i,
  output logic              OUT_LAST_o,
  output logic              BUSY_o,
  output logic              DONE_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FIN
  } state_t;

  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;

  always_ff @(posedge CLK_i) begin
    if (RES_i) begin
      state        <= S_IDLE;
      addr         <= '0;
      remaining    <= '0;
      RF_RD_EN_o   <= 1'b0;
      RF_RD_ADDR_o <= '0;
      OUT_DATA_o   <= '0;
      OUT_VALID_o  <= 1'b0;
      OUT_LAST_o   <= 1'b0;
      BUSY_o       <= 1'b0;
      DONE_o       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START_i) begin
            BUSY_o <= 1'b1;
            if (LEN_i == '0) begin
              state  <= S_FIN;
              DONE_o <= 1'b1;
            end else begin
              addr         <= BASE_ADDR_i;
              remaining    <= (LEN_i > LEN_MAX) ? LEN_MAX : LEN_i;
              state        <= S_REQ;
              RF_RD_EN_o   <= 1'b1;
              RF_RD_ADDR_o <= BASE_ADDR_i;
            end
          end
        end
        S_REQ: begin
          RF_RD_EN_o   <= 1'b0;
          RF_RD_ADDR_o <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          // addr wraps naturally because DEPTH is a power of two
          OUT_DATA_o  <= RF_RD_DATA_i;
          addr        <= addr + ADDR_ONE;
          remaining   <= remaining - LEN_ONE;
          OUT_VALID_o <= 1'b1;
          OUT_LAST_o  <= (remaining == LEN_ONE);
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (OUT_READY_i) begin
            OUT_VALID_o <= 1'b0;
            OUT_LAST_o  <= 1'b0;
            if (remaining != '0) begin
              state        <= S_REQ;
              RF_RD_EN_o   <= 1'b1;
              RF_RD_ADDR_o <= addr;
            end else begin
              state  <= S_FIN;
              DONE_o <= 1'b1;
            end
          end
        end
        S_FIN: begin
          DONE_o <= 1'b0;
          BUSY_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: starts are turned into expected read addresses and beats,
// a negedge monitor pops and compares them along with BUSY/DONE timing and HOLD stability.
module tb_regfile_reader;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              CLK_i = 1'b0;
  logic              RES_i = 1'b1;
  logic              START_i = 1'b0;
  logic [ADDR_W-1:0] BASE_ADDR_i = '0;
  logic [ADDR_W:0]   LEN_i = '0;
  logic              RF_RD_EN_o;
  logic [ADDR_W-1:0] RF_RD_ADDR_o;
  logic [DATA_W-1:0] RF_RD_DATA_i = '0;
  logic [DATA_W-1:0] OUT_DATA_o;
  logic              OUT_VALID_o;
  logic              OUT_READY_i = 1'b0;
  logic              OUT_LAST_o;
  logic              BUSY_o;
  logic              DONE_o;

  regfile_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK_i        (CLK_i),
    .RES_i        (RES_i),
    .START_i      (START_i),
    .BASE_ADDR_i  (BASE_ADDR_i),
    .LEN_i        (LEN_i),
    .RF_RD_EN_o   (RF_RD_EN_o),
    .RF_RD_ADDR_o (RF_RD_ADDR_o),
    .RF_RD_DATA_i (RF_RD_DATA_i),
    .OUT_DATA_o   (OUT_DATA_o),
    .OUT_VALID_o  (OUT_VALID_o),
    .OUT_READY_i  (OUT_READY_i),
    .OUT_LAST_o   (OUT_LAST_o),
    .BUSY_o       (BUSY_o),
    .DONE_o       (DONE_o)
  );

  always #5 CLK_i = ~CLK_i;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              last;
  } beat_t;

  int                n_cmp = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] rf [DEPTH];
  beat_t             beat_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  bit                m_busy = 1'b0;
  bit                m_done = 1'b0;
  bit                rd_pend = 1'b0;
  logic [ADDR_W-1:0] rd_a = '0;
  bit                stall = 1'b0;
  beat_t             stall_b;
  bit                mon_fin, mon_nb, mon_nd;
  int                mon_n;
  beat_t             mon_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not matched by expectation at %0t", name, $time);
  endtask

  // Storage model: data valid the cycle after the strobe, junk otherwise.
  initial forever begin
    @(posedge CLK_i);
    #1;
    RF_RD_DATA_i = rd_pend ? rf[rd_a] : DATA_W'($urandom);
  end

  always @(negedge CLK_i) begin
    if (RES_i) begin
      beat_q.delete();
      addr_q.delete();
      m_busy  = 1'b0;
      m_done  = 1'b0;
      stall   = 1'b0;
      rd_pend = 1'b0;
    end else begin
      mon_fin = 1'b0;
      chk("busy", 32'(BUSY_o), 32'(m_busy));
      chk("done", 32'(DONE_o), 32'(m_done));
      rd_pend = RF_RD_EN_o;
      rd_a    = RF_RD_ADDR_o;
      if (RF_RD_EN_o) begin
        if (addr_q.size() == 0) fail_msg("rd_en_unexpected");
        else chk("rd_addr", 32'(RF_RD_ADDR_o), 32'(addr_q.pop_front()));
      end else begin
        chk("rd_addr_idle", 32'(RF_RD_ADDR_o), 32'd0);
      end
      if (stall) begin
        chk("hold_valid", 32'(OUT_VALID_o), 32'd1);
        chk("hold_data", 32'(OUT_DATA_o), 32'(stall_b.dat));
        chk("hold_last", 32'(OUT_LAST_o), 32'(stall_b.last));
      end
      stall   = OUT_VALID_o && !OUT_READY_i;
      stall_b = {OUT_DATA_o, OUT_LAST_o};
      if (OUT_VALID_o && OUT_READY_i) begin
        if (beat_q.size() == 0) begin
          fail_msg("beat_unexpected");
        end else begin
          mon_b = beat_q.pop_front();
          chk("out_data", 32'(OUT_DATA_o), 32'(mon_b.dat));
          chk("out_last", 32'(OUT_LAST_o), 32'(mon_b.last));
          mon_fin = mon_b.last;
        end
      end
      mon_nd = mon_fin;
      mon_nb = m_busy;
      if (m_done) mon_nb = 1'b0;
      if (START_i && !m_busy) begin
        mon_n  = (int'(LEN_i) > DEPTH) ? DEPTH : int'(LEN_i);
        mon_nb = 1'b1;
        if (mon_n == 0) mon_nd = 1'b1;
        for (int k = 0; k < mon_n; k++) begin
          addr_q.push_back(ADDR_W'((int'(BASE_ADDR_i) + k) % DEPTH));
          beat_q.push_back({rf[(int'(BASE_ADDR_i) + k) % DEPTH], (k == mon_n - 1)});
        end
      end
      m_busy = mon_nb;
      m_done = mon_nd;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_i);
    #1;
  endtask

  task automatic apply_reset();
    RES_i = 1'b1;
    @(posedge CLK_i);
    @(negedge CLK_i);
    chk("rst_rd_en", 32'(RF_RD_EN_o), 32'd0);
    chk("rst_rd_addr", 32'(RF_RD_ADDR_o), 32'd0);
    chk("rst_data", 32'(OUT_DATA_o), 32'd0);
    chk("rst_valid", 32'(OUT_VALID_o), 32'd0);
    chk("rst_last", 32'(OUT_LAST_o), 32'd0);
    chk("rst_busy", 32'(BUSY_o), 32'd0);
    chk("rst_done", 32'(DONE_o), 32'd0);
    @(posedge CLK_i);
    #1;
    RES_i = 1'b0;
  endtask

  task automatic start(input int base, input int len);
    START_i     = 1'b1;
    BASE_ADDR_i = ADDR_W'(base);
    LEN_i       = (ADDR_W+1)'(len);
    cyc(1);
    START_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit rnd);
    for (int i = 0; i < 600 && m_busy; i++) begin
      if (rnd) begin
        OUT_READY_i = ($urandom_range(0, 3) != 0);
        START_i     = ($urandom_range(0, 9) == 0);
        BASE_ADDR_i = ADDR_W'($urandom_range(0, DEPTH - 1));
        LEN_i       = (ADDR_W+1)'($urandom_range(0, 15));
      end
      cyc(1);
    end
    START_i = 1'b0;
    if (m_busy) begin
      fail_msg({name, "_timeout"});
      apply_reset();
    end
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_i);
      if (OUT_VALID_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_msg({name, "_no_valid"});
  endtask

  task automatic fill_rf_random();
    for (int k = 0; k < DEPTH; k++) rf[k] = DATA_W'($urandom);
  endtask

  initial begin
    int b;
    int cnt;
    for (int k = 0; k < DEPTH; k++) rf[k] = DATA_W'(8'h10 + k);
    OUT_READY_i = 1'b1;
    apply_reset();
    cyc(1);

    // Plain burst, then a wrapping burst.
    start(2, 3);
    wait_idle("t1", 1'b0);
    fill_rf_random();
    start(6, 4);
    wait_idle("t2", 1'b0);

    // Long stall in the first HOLD; the captured entry is overwritten meanwhile.
    fill_rf_random();
    OUT_READY_i = 1'b0;
    b = $urandom_range(0, DEPTH - 1);
    start(b, 2);
    wait_valid("t3");
    rf[b] = ~rf[b];
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(RF_RD_EN_o);
      chk("t3_valid", 32'(OUT_VALID_o), 32'd1);
      @(negedge CLK_i);
    end
    chk("t3_no_rd_en", 32'(cnt), 32'd0);
    @(posedge CLK_i);
    #1;
    OUT_READY_i = 1'b1;
    wait_idle("t3", 1'b0);

    // Zero-length burst.
    start($urandom_range(0, DEPTH - 1), 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_i);
      cnt += int'(RF_RD_EN_o) + int'(OUT_VALID_o);
    end
    chk("t4_no_activity", 32'(cnt), 32'd0);
    cyc(1);
    wait_idle("t4", 1'b0);

    // START mid-burst must be ignored.
    fill_rf_random();
    start(5, 4);
    cyc(3);
    START_i     = 1'b1;
    BASE_ADDR_i = '0;
    LEN_i       = (ADDR_W+1)'(3);
    cyc(1);
    START_i = 1'b0;
    wait_idle("t5", 1'b0);

    // Reset while holding a word, then a fresh single-word burst.
    OUT_READY_i = 1'b0;
    start(3, 4);
    wait_valid("t6");
    @(posedge CLK_i);
    #1;
    apply_reset();
    OUT_READY_i = 1'b1;
    start($urandom_range(0, DEPTH - 1), 1);
    wait_idle("t6", 1'b0);

    // Randomized bursts, including clamped lengths, random READY and ignored STARTs.
    repeat (40) begin
      fill_rf_random();
      start($urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
      wait_idle("rand", 1'b1);
      OUT_READY_i = 1'b1;
      cyc(1);
    end

    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("reads_left", 32'(addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
